// File: rtl/z80_mmu_pt_loader.sv
// Z80 MMU page-table loader: bus master that writes a run of page-table
// entries (low byte, then high byte) into the MMU window at 0xFE00-0xFFFF.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     1-clk pulse; accepted only when idle
//   first_page, num_pages     first virtual page and entry count (0..256)
//   base_frame, flags         frame for first_page, flag nibble for all
//   bus_req / bus_ack         CPU-side bus request / grant handshake
//   bus_oe                    loader drives the MMU bus signals below
//   nMREQ, nRD, nWR           active-low bus strobes (nRD held high)
//   virtual_addr, cpu_data    MMU address and write data
//   busy, done, error         status; done/error are 1-clk pulses
module z80_mmu_pt_loader #(
    parameter int FLAGS     = 4,
    parameter int PA        = 12,
    parameter int WR_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       first_page,
    input  logic [8:0]       num_pages,
    input  logic [PA-1:0]    base_frame,
    input  logic [FLAGS-1:0] flags,
    output logic             bus_req,
    input  logic             bus_ack,
    output logic             bus_oe,
    output logic             nMREQ,
    output logic             nRD,
    output logic             nWR,
    output logic [15:0]      virtual_addr,
    output logic [7:0]       cpu_data,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WR_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_STROBE  = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ABORT   = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hi_q, hi_d;
    logic [7:0]       page_q, page_d;
    logic [PA-1:0]    frame_q, frame_d;
    logic [8:0]       left_q, left_d;
    logic [FLAGS-1:0] flags_q, flags_d;

    logic             req_q, req_d;
    logic             oe_q, oe_d;
    logic             nwr_q, nwr_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [8:0]       n_clamp;

    assign n_clamp = (num_pages > 9'd256) ? 9'd256 : num_pages;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        page_d  = page_q;
        frame_d = frame_q;
        left_d  = left_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    page_d  = first_page;
                    frame_d = base_frame;
                    flags_d = flags;
                    left_d  = n_clamp;
                    hi_d    = 1'b0;
                    state_d = (n_clamp == 9'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_ack) state_d = S_SETUP;
            end
            S_SETUP: begin
                cnt_d   = CNT_LAST;
                state_d = bus_ack ? S_STROBE : S_ABORT;
            end
            S_STROBE: begin
                if (!bus_ack) begin
                    state_d = S_ABORT;
                end else if (cnt_q == '0) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (!bus_ack) begin
                    state_d = S_ABORT;
                end else if (!hi_q) begin
                    hi_d    = 1'b1;
                    state_d = S_SETUP;
                end else if (left_q == 9'd1) begin
                    state_d = S_RELEASE;
                end else begin
                    // Page and frame both wrap naturally at their widths.
                    hi_d    = 1'b0;
                    page_d  = page_q + 1'b1;
                    frame_d = frame_q + 1'b1;
                    left_d  = left_q - 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_RELEASE: begin
                if (!bus_ack) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered
        // and change on the same edge as the state they belong to.
        oe_d   = (state_d == S_SETUP) || (state_d == S_STROBE) ||
                 (state_d == S_HOLD);
        req_d  = oe_d || (state_d == S_REQ);
        nwr_d  = (state_d != S_STROBE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ABORT);
        addr_d = 16'h0000;
        data_d = 8'h00;
        if (oe_d) begin
            addr_d = {7'b1111111, page_d, hi_d};
            data_d = hi_d ? {flags_d, frame_d[PA-1:8]} : frame_d[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= 1'b0;
            page_q  <= 8'h00;
            frame_q <= '0;
            left_q  <= 9'd0;
            flags_q <= '0;
            req_q   <= 1'b0;
            oe_q    <= 1'b0;
            nwr_q   <= 1'b1;
            addr_q  <= 16'h0000;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            page_q  <= page_d;
            frame_q <= frame_d;
            left_q  <= left_d;
            flags_q <= flags_d;
            req_q   <= req_d;
            oe_q    <= oe_d;
            nwr_q   <= nwr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // nMREQ and nWR share one flop so they can never skew apart.
    assign bus_req      = req_q;
    assign bus_oe       = oe_q;
    assign nMREQ        = nwr_q;
    assign nWR          = nwr_q;
    assign nRD          = 1'b1;
    assign virtual_addr = addr_q;
    assign cpu_data     = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = err_q;

endmodule

// File: tb/tb_z80_mmu_pt_loader.sv
// Randomized self-checking bench for z80_mmu_pt_loader with a
// byte-level write model and a per-cycle bus monitor.
module tb_z80_mmu_pt_loader;

    localparam int WR = 2;
    localparam int C  = WR + 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  first_page;
    logic [8:0]  num_pages;
    logic [11:0] base_frame;
    logic [3:0]  flags;
    logic        bus_req;
    logic        bus_ack;
    logic        bus_oe;
    logic        nMREQ;
    logic        nRD;
    logic        nWR;
    logic [15:0] virtual_addr;
    logic [7:0]  cpu_data;
    logic        busy;
    logic        done;
    logic        error;

    z80_mmu_pt_loader #(.FLAGS(4), .PA(12), .WR_CYCLES(WR)) dut (
        .clk(clk), .rst(rst), .start(start),
        .first_page(first_page), .num_pages(num_pages),
        .base_frame(base_frame), .flags(flags),
        .bus_req(bus_req), .bus_ack(bus_ack), .bus_oe(bus_oe),
        .nMREQ(nMREQ), .nRD(nRD), .nWR(nWR),
        .virtual_addr(virtual_addr), .cpu_data(cpu_data),
        .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [23:0] exp_q[$];
    logic [23:0] log_q[$];
    int          full_cnt = 0;
    int          part_cnt = 0;
    int          last_oe = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Byte k of a load: entry k/2, low byte if k even, high byte if odd.
    function automatic logic [23:0] exp_write(input logic [7:0] fp,
            input logic [11:0] bf, input logic [3:0] fl, input int k);
        int i, hi, p, f, a, d;
        i  = k / 2;
        hi = k % 2;
        p  = (int'(fp) + i) % 256;
        f  = (int'(bf) + i) % 4096;
        a  = 'hFE00 + p * 2 + hi;
        d  = hi ? (int'(fl) * 16 + f / 256) : (f % 256);
        return {a[15:0], d[7:0]};
    endfunction

    // Per-cycle bus monitor and write scoreboard.
    logic        prev_nwr = 1'b1;
    int          width = 0;
    logic [15:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    logic [23:0] e;

    always @(negedge clk) begin
        if (rst) begin
            prev_nwr = 1'b1;
            width    = 0;
        end else begin
            chk("nrd_high", nRD, 1);
            chk("mreq_eq_wr", nMREQ, nWR);
            if (bus_oe) begin
                chk("oe_has_req", bus_req, 1);
            end else begin
                chk("idle_addr", virtual_addr, 0);
                chk("idle_data", cpu_data, 0);
                chk("idle_wr", nWR, 1);
            end
            if (!nWR) begin
                if (!prev_nwr) begin
                    chk("addr_stable", virtual_addr, prev_addr);
                    chk("data_stable", cpu_data, prev_data);
                end
                width++;
                prev_addr = virtual_addr;
                prev_data = cpu_data;
            end else if (!prev_nwr) begin
                if (width == WR) begin
                    full_cnt++;
                    log_q.push_back({prev_addr, prev_data});
                    if (exp_q.size() == 0) begin
                        chk("write_expected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", prev_addr, e[23:8]);
                        chk("wr_data", prev_data, e[7:0]);
                    end
                end else if (width > WR) begin
                    chk("strobe_width", width, WR);
                end else begin
                    part_cnt++;
                end
                width = 0;
            end
            prev_nwr = nWR;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"}, bus_req, 0);
        chk({tag, "_oe"}, bus_oe, 0);
        chk({tag, "_mreq"}, nMREQ, 1);
        chk({tag, "_rd"}, nRD, 1);
        chk({tag, "_wr"}, nWR, 1);
        chk({tag, "_addr"}, virtual_addr, 0);
        chk({tag, "_data"}, cpu_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, error, 0);
    endtask

    task automatic run_load(input logic [7:0] fp, input int np,
            input logic [11:0] bf, input logic [3:0] fl, input int gd,
            input int abort_at, input int rd, input bit extra);
        int n, j, budget, fc0, pc0, b, ph, xf, xp;
        bit fin;
        n = (np > 256) ? 256 : np;
        exp_q.delete();
        log_q.delete();
        for (int k = 0; k < 2 * n; k++) exp_q.push_back(exp_write(fp, bf, fl, k));
        fc0 = full_cnt;
        pc0 = part_cnt;
        @(negedge clk);
        start = 1'b1;
        first_page = fp;
        num_pages = 9'(np);
        base_frame = bf;
        flags = fl;
        @(negedge clk);
        start = 1'b0;
        first_page = 8'($urandom);
        num_pages = 9'($urandom);
        base_frame = 12'($urandom);
        flags = 4'($urandom);
        chk("busy_after_start", busy, 1);
        if (n == 0) begin
            chk("zero_done", done, 1);
            chk("zero_req", bus_req, 0);
            @(negedge clk);
            chk("zero_done_end", done, 0);
            chk("zero_busy_end", busy, 0);
            chk("zero_req_end", bus_req, 0);
            return;
        end
        chk("req_after_start", bus_req, 1);
        chk("no_early_done", done, 0);
        repeat (gd) begin
            @(negedge clk);
            chk("req_wait_no_oe", bus_oe, 0);
            chk("req_wait_req", bus_req, 1);
        end
        bus_ack = 1'b1;
        j = 0;
        fin = 0;
        budget = 0;
        while (!fin && budget < 5000) begin
            @(negedge clk);
            budget++;
            if (start) start = 1'b0;
            if (bus_oe) begin
                if (extra && j == 3) begin
                    start = 1'b1;
                    first_page = 8'h55;
                    num_pages = 9'd5;
                end
                if (j == abort_at) bus_ack = 1'b0;
                j++;
            end else if (abort_at >= 0 && j > abort_at) begin
                fin = 1;
                chk("abort_err", error, 1);
                chk("abort_req", bus_req, 0);
                chk("abort_wr", nWR, 1);
                chk("abort_busy", busy, 1);
                chk("abort_done", done, 0);
                chk("abort_oe_cycles", j, abort_at + 1);
                @(negedge clk);
                chk("abort_err_end", error, 0);
                chk("abort_busy_end", busy, 0);
                b = abort_at / C;
                ph = abort_at % C;
                xf = b + ((ph >= WR) ? 1 : 0);
                xp = (ph >= 1 && ph < WR) ? 1 : 0;
                chk("abort_full_writes", full_cnt - fc0, xf);
                chk("abort_partial", part_cnt - pc0, xp);
            end else if (j > 0) begin
                fin = 1;
                last_oe = j;
                chk("rel_req", bus_req, 0);
                chk("rel_busy", busy, 1);
                chk("rel_done", done, 0);
                chk("load_cycles", j, 2 * n * C);
                repeat (rd) begin
                    @(negedge clk);
                    chk("rel_wait_done", done, 0);
                    chk("rel_wait_req", bus_req, 0);
                end
                bus_ack = 1'b0;
                @(negedge clk);
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 1);
                chk("done_no_err", error, 0);
                @(negedge clk);
                chk("done_end", done, 0);
                chk("busy_end", busy, 0);
                chk("full_writes", full_cnt - fc0, 2 * n);
                chk("partial_none", part_cnt - pc0, 0);
                chk("exp_drained", exp_q.size(), 0);
            end
        end
        if (!fin) begin
            chk("load_timeout", fin, 1);
            rst = 1'b1;
            bus_ack = 1'b0;
            start = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
        if (extra) begin
            repeat (8) begin
                @(negedge clk);
                chk("no_second_load_req", bus_req, 0);
                chk("no_second_load_busy", busy, 0);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        int n, ab, bud;
        rst = 1'b1;
        start = 1'b0;
        bus_ack = 1'b0;
        first_page = '0;
        num_pages = '0;
        base_frame = '0;
        flags = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Single entry, grant after 2 clocks.
        run_load(8'h00, 1, 12'h08E, 4'h0, 2, -1, 1, 0);
        chk("t1_len", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t1_w0", log_q[0], 24'hFE008E);
            chk("t1_w1", log_q[1], 24'hFE0100);
        end

        // Page and frame wrap.
        run_load(8'hFE, 3, 12'hFFF, 4'hA, 1, -1, 0, 0);
        chk("t2_len", log_q.size(), 6);
        if (log_q.size() == 6) begin
            chk("t2_w0", log_q[0], 24'hFFFCFF);
            chk("t2_w1", log_q[1], 24'hFFFDAF);
            chk("t2_w2", log_q[2], 24'hFFFE00);
            chk("t2_w3", log_q[3], 24'hFFFFA0);
            chk("t2_w4", log_q[4], 24'hFE0001);
            chk("t2_w5", log_q[5], 24'hFE01A0);
        end

        // Zero-length load.
        run_load(8'h12, 0, 12'h345, 4'h6, 0, -1, 0, 0);

        // Full table and clamped count.
        run_load(8'h80, 256, 12'h7F0, 4'h3, 0, -1, 2, 0);
        chk("t4_writes", log_q.size(), 512);
        chk("t4_cycles", last_oe, 2048);
        run_load(8'h00, 300, 12'h001, 4'hC, 3, -1, 0, 0);
        chk("clamp_writes", log_q.size(), 512);

        // Grant lost in the first strobe clock of entry 3's high byte.
        run_load(8'h10, 6, 12'h123, 4'h5, 1, 7 * C + 1, 0, 0);
        chk("t5_len", log_q.size(), 7);
        if (log_q.size() == 7) chk("t5_last", log_q[6], 24'hFE2626);

        // Reset in the middle of a strobe.
        exp_q.delete();
        @(negedge clk);
        start = 1'b1;
        first_page = 8'h40;
        num_pages = 9'd4;
        base_frame = 12'h100;
        flags = 4'h1;
        @(negedge clk);
        start = 1'b0;
        bus_ack = 1'b1;
        bud = 0;
        while (nWR !== 1'b0 && bud < 50) begin
            @(negedge clk);
            bud++;
        end
        chk("t6_strobe_seen", nWR, 0);
        rst = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_err", error, 0);
            chk("post_rst_busy", busy, 0);
        end

        // Start pulsed while busy must not launch a second load.
        run_load(8'h20, 2, 12'h0AB, 4'h9, 1, -1, 1, 1);

        // Randomized loads, some with grant loss.
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(0, 20);
            ab = -1;
            if (n > 0 && $urandom_range(0, 2) == 0)
                ab = $urandom_range(0, 2 * n * C - 1);
            run_load(8'($urandom), n, 12'($urandom), 4'($urandom),
                     $urandom_range(0, 3), ab, $urandom_range(0, 3), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
